// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver, 5-9 data bits, none/odd/even parity, 1-2 stop bits.
// Optional feature macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority around the bit centre.
module uart_rx_param #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] rxOut
);

    localparam int BAUD_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TICK_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(OVERSAMPLE / 2);
`else
    localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Parity error for a received word and parity bit (odd: XOR must be 1, even: XOR must be 0).
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
        logic x;
        x = (^data) ^ par_bit;
        return (PARITY == 1) ? ~x : x;
    endfunction

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_e                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic                  armed_q, armed_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  frm_err_q, frm_err_d;
    logic                  par_err_q, par_err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  perr_q, perr_d;
    logic [DATA_BITS-1:0]  out_q, out_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]            maj_q, maj_d;
`endif

    logic rx_sync_s;
    logic tick_s;
    logic sample_s;
    logic bit_end_s;
    logic bit_val_s;
    logic start_s;

    assign rx_sync_s = sync_q[1];
    assign tick_s    = (div_q == DIV_LAST);
    assign sample_s  = tick_s && (tick_cnt_q == SAMPLE_TICK);
    assign bit_end_s = tick_s && (tick_cnt_q == TICK_LAST);
    // armed_q holds last cycle's line level in IDLE, so this is a qualified 1->0 edge.
    assign start_s   = (state_q == ST_IDLE) && armed_q && !rx_sync_s && rxEn;

`ifdef UART_RX_MAJORITY_EN
    assign bit_val_s = maj3_f(maj_q[1], maj_q[0], rx_sync_s);
`else
    assign bit_val_s = rx_sync_s;
`endif

    // Next-state logic for the tick generator, frame FSM and output registers.
    always_comb begin
        sync_d     = {sync_q[0], rxIn};
        state_d    = state_q;
        armed_d    = armed_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frm_err_d  = frm_err_q;
        par_err_d  = par_err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        perr_d     = 1'b0;
        out_d      = out_q;
`ifdef UART_RX_MAJORITY_EN
        maj_d      = tick_s ? {maj_q[0], rx_sync_s} : maj_q;
`endif
        if (tick_s) begin
            div_d      = '0;
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_ONE;
        end else begin
            div_d      = div_q + DIV_ONE;
            tick_cnt_d = tick_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_s) begin
                    state_d    = ST_START;
                    busy_d     = 1'b1;
                    armed_d    = 1'b0;
                    div_d      = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = 4'd0;
                    frm_err_d  = 1'b0;
                    par_err_d  = 1'b0;
                end else begin
                    armed_d = rx_sync_s;
                end
            end
            ST_START: begin
                if (sample_s && bit_val_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_d = {bit_val_s, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    par_err_d = parity_err_f(shift_q, bit_val_s);
                end else begin
                    par_err_d = par_err_q;
                end
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    frm_err_d = frm_err_q | ~bit_val_s;
                    // Completion is at the last stop sample; the rest of that bit is ignored.
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        armed_d = 1'b0;
                        done_d  = 1'b1;
                        err_d   = frm_err_q | ~bit_val_s;
                        perr_d  = par_err_q;
                        out_d   = shift_q;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (bit_end_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                armed_d = 1'b0;
            end
        endcase

        // Disabling the receiver drops any frame in flight without reporting it.
        if (!rxEn && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            armed_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            perr_d  = 1'b0;
            out_d   = out_q;
        end else begin
            out_d   = out_d;
        end
    end

    // State and output registers; the synchronizer resets to the idle-high line level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
            out_q      <= '0;
`ifdef UART_RX_MAJORITY_EN
            maj_q      <= 2'b11;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            armed_q    <= armed_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frm_err_q  <= frm_err_d;
            par_err_q  <= par_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            perr_q     <= perr_d;
            out_q      <= out_d;
`ifdef UART_RX_MAJORITY_EN
            maj_q      <= maj_d;
`endif
        end
    end

    assign rxBusy      = busy_q;
    assign rxDone      = done_q;
    assign rxErr       = err_q;
    assign rxParityErr = perr_q;
    assign rxOut       = out_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default 8N1, fast 8N1 and fast 7E2 instances.
module tb_uart_rx_param;

    localparam int FAST_CLK = 614400;
    localparam int BIT_D    = 1248;
    localparam int BIT_F    = 64;

    typedef struct packed {
        logic [8:0] data;
        logic       err;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] rx_line;
    logic [2:0] rx_en;

    logic       busy0, done0, err0, perr0;
    logic [7:0] out0;
    logic       busy1, done1, err1, perr1;
    logic [6:0] out1;
    logic       busy2, done2, err2, perr2;
    logic [7:0] out2;

    exp_t q_def[$];
    exp_t q_par[$];
    exp_t q_fast[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_param u_def (
        .clk(clk), .rstN(rstN), .rxEn(rx_en[0]), .rxIn(rx_line[0]),
        .rxBusy(busy0), .rxDone(done0), .rxErr(err0), .rxParityErr(perr0), .rxOut(out0)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLK), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_par (
        .clk(clk), .rstN(rstN), .rxEn(rx_en[1]), .rxIn(rx_line[1]),
        .rxBusy(busy1), .rxDone(done1), .rxErr(err1), .rxParityErr(perr1), .rxOut(out1)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLK)) u_fast (
        .clk(clk), .rstN(rstN), .rxEn(rx_en[2]), .rxIn(rx_line[2]),
        .rxBusy(busy2), .rxDone(done2), .rxErr(err2), .rxParityErr(perr2), .rxOut(out2)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [8:0] data,
                              input logic err, input logic perr);
        chk({tag, "_data"}, 16'(data), 16'(e.data));
        chk({tag, "_err"},  16'(err),  16'(e.err));
        chk({tag, "_perr"}, 16'(perr), 16'(e.perr));
    endtask

    task automatic unexpected(input string tag);
        total++;
        bad++;
        $display("FAIL %s_unexpected_done: got rxDone=1 required rxDone=0", tag);
    endtask

    // Monitors: pop the next expected frame whenever a receiver reports one.
    always @(negedge clk) begin
        if (rstN && done0) begin
            if (q_def.size() == 0) unexpected("def");
            else check_done("def", q_def.pop_front(), 9'(out0), err0, perr0);
        end
    end

    always @(negedge clk) begin
        if (rstN && done1) begin
            if (q_par.size() == 0) unexpected("par");
            else check_done("par", q_par.pop_front(), 9'(out1), err1, perr1);
        end
    end

    always @(negedge clk) begin
        if (rstN && done2) begin
            if (q_fast.size() == 0) unexpected("fast");
            else check_done("fast", q_fast.pop_front(), 9'(out2), err2, perr2);
        end
    end

    // Drives n line bits LSB-first; bit glitch_idx gets a one-tick inverted pulse near its centre.
    task automatic send_bits(input int which, input logic [15:0] bits, input int n,
                             input int bitclk, input int glitch_idx);
        for (int i = 0; i < n; i++) begin
            rx_line[which] = bits[i];
            if (i == glitch_idx) begin
                repeat (30) @(posedge clk);
                #1 rx_line[which] = ~bits[i];
                repeat (4) @(posedge clk);
                #1 rx_line[which] = bits[i];
                repeat (bitclk - 34) @(posedge clk);
            end else begin
                repeat (bitclk) @(posedge clk);
            end
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [7:0] exp_a3;
`ifdef UART_RX_MAJORITY_EN
        exp_a3 = 8'hA3;
`else
        exp_a3 = 8'hA7;
`endif
        rstN    = 1'b0;
        rx_line = 3'b111;
        rx_en   = 3'b111;
        idle(3);
        chk("rst_busy",  16'(busy0), 16'd0);
        chk("rst_done",  16'(done0), 16'd0);
        chk("rst_err",   16'(err0),  16'd0);
        chk("rst_perr",  16'(perr0), 16'd0);
        chk("rst_out",   16'(out0),  16'd0);
        chk("rst_out_p", 16'(out1),  16'd0);
        rstN = 1'b1;
        idle(8);

        // Clean 8N1 frame at full default rate, including start-detect latency.
        e = '{data: 9'h055, err: 1'b0, perr: 1'b0};
        q_def.push_back(e);
        rx_line[0] = 1'b0;
        idle(2);
        chk("start_busy_2clk", 16'(busy0), 16'd0);
        idle(1);
        chk("start_busy_3clk", 16'(busy0), 16'd1);
        idle(BIT_D - 3);
        send_bits(0, 16'({1'b1, 8'h55}), 9, BIT_D, -1);
        idle(BIT_D);
        chk("clean_busy_after", 16'(busy0), 16'd0);
        chk("clean_out",        16'(out0),  16'h55);

        // Glitch late in the stop bit must not corrupt the frame or start a new one.
        e = '{data: 9'h055, err: 1'b0, perr: 1'b0};
        q_fast.push_back(e);
        send_bits(2, 16'({8'h55, 1'b0}), 9, BIT_F, -1);
        rx_line[2] = 1'b1;
        idle(38);
        rx_line[2] = 1'b0;
        idle(20);
        rx_line[2] = 1'b1;
        idle(6 + 2 * BIT_F);
        chk("sglitch_out",  16'(out2),  16'h55);
        chk("sglitch_busy", 16'(busy2), 16'd0);

        // Framing error, then a held-low line must not retrigger.
        e = '{data: 9'h00F, err: 1'b1, perr: 1'b0};
        q_fast.push_back(e);
        send_bits(2, 16'({1'b0, 8'h0F, 1'b0}), 10, BIT_F, -1);
        idle(3 * BIT_F);
        chk("frm_busy_held_low", 16'(busy2), 16'd0);
        rx_line[2] = 1'b1;
        idle(2 * BIT_F);
        chk("frm_busy_after_high", 16'(busy2), 16'd0);
        chk("frm_out",             16'(out2),  16'h0F);

        // False start: 4-tick low pulse.
        rx_line[2] = 1'b0;
        idle(16);
        rx_line[2] = 1'b1;
        chk("fs_busy_set",   16'(busy2), 16'd1);
        idle(BIT_F);
        chk("fs_busy_clear", 16'(busy2), 16'd0);

        // Abort after data bit 3 by dropping rxEn.
        send_bits(2, 16'({4'h6, 1'b0}), 5, BIT_F, -1);
        chk("abort_busy_before", 16'(busy2), 16'd1);
        rx_en[2] = 1'b0;
        idle(1);
        chk("abort_busy_after", 16'(busy2), 16'd0);
        chk("abort_out_hold",   16'(out2),  16'h0F);
        send_bits(2, 16'({1'b1, 4'h9}), 5, BIT_F, -1);
        idle(2 * BIT_F);
        rx_en[2] = 1'b1;
        idle(2 * BIT_F);
        chk("abort_idle_busy", 16'(busy2), 16'd0);

        // Back-to-back frames with a one-tick glitch at the centre of data bit 2.
        e = '{data: 9'(exp_a3), err: 1'b0, perr: 1'b0};
        q_fast.push_back(e);
        e = '{data: 9'h03C, err: 1'b0, perr: 1'b0};
        q_fast.push_back(e);
        send_bits(2, 16'({1'b1, 8'hA3, 1'b0}), 10, BIT_F, 3);
        send_bits(2, 16'({1'b1, 8'h3C, 1'b0}), 10, BIT_F, -1);
        idle(2 * BIT_F);
        chk("b2b_out",  16'(out2),  16'h3C);
        chk("b2b_busy", 16'(busy2), 16'd0);

        // 7E2: good parity bit, then bad parity bit, back-to-back.
        e = '{data: 9'h025, err: 1'b0, perr: 1'b0};
        q_par.push_back(e);
        e = '{data: 9'h025, err: 1'b0, perr: 1'b1};
        q_par.push_back(e);
        send_bits(1, 16'({2'b11, 1'b1, 7'h25, 1'b0}), 11, BIT_F, -1);
        send_bits(1, 16'({2'b11, 1'b0, 7'h25, 1'b0}), 11, BIT_F, -1);
        idle(2 * BIT_F);
        chk("par_out",  16'(out1),  16'h25);
        chk("par_busy", 16'(busy1), 16'd0);

        chk("def_pending",  16'(q_def.size()),  16'd0);
        chk("par_pending",  16'(q_par.size()),  16'd0);
        chk("fast_pending", 16'(q_fast.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
